system_qsys_nios2_debug_cmd_queue: RTL and testbench

SYSTEM_QSYS_NIOS2_DEBUG_CMD_QUEUE -- requirements
Module: system_qsys_nios2_debug_cmd_queue

---
 rtl/system_qsys_nios2_debug_cmd_queue.sv | 125 ++++++++++++
 tb/tb_system_qsys_nios2_debug_cmd_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/system_qsys_nios2_debug_cmd_queue.sv
// Debug command queue: synchronizes JTAG update-DR/IR strobes into clk, queues
// captured {ir, sr} commands and issues them as one-hot action pulses.
module system_qsys_nios2_debug_cmd_queue #(
    parameter int IR_W        = 2,
    parameter int SR_W        = 38,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int NCH        = 2**IR_W,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SR_W-1:0]   sr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic              cmd_ready,
    input  logic              clr_ovf,
    output logic [SR_W-1:0]   jdo,
    output logic [NCH-1:0]    take_action,
    output logic [NCH-1:0]    take_no_action,
    output logic [AW:0]       fifo_level,
    output logic              overflow,
    output logic              ir_update
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
    logic                   udr_dly, uir_dly;
    logic                   udr_rise, uir_rise;

    logic [IR_W+SR_W-1:0]   mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [IR_W+SR_W-1:0]   head;
    logic [IR_W-1:0]        head_ir;
    logic [SR_W-1:0]        head_sr;
    logic [NCH-1:0]         head_onehot;
    logic                   full, empty, pop, push_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_dly  <= 1'b0;
            uir_dly  <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_dly  <= udr_sync[SYNC_STAGES-1];
            uir_dly  <= uir_sync[SYNC_STAGES-1];
        end
    end

    assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_dly;
    assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_dly;

    assign full    = (fifo_level == FULL_LVL);
    assign empty   = (fifo_level == '0);
    assign pop     = ~empty & cmd_ready;
    // A full queue still accepts the push when the head leaves on the same edge.
    assign push_ok = udr_rise & (~full | pop);

    assign head    = mem[rd_ptr];
    assign head_ir = head[SR_W +: IR_W];
    assign head_sr = head[SR_W-1:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        head_onehot          = '0;
        head_onehot[head_ir] = 1'b1;
    end

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // pointers and level, which are.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {ir_in, sr};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                jdo <= head_sr;
                if (head_sr[SR_W-1]) take_action    <= head_onehot;
                else                 take_no_action <= head_onehot;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            ir_update <= 1'b0;
        end else begin
            ir_update <= uir_rise;
            if (udr_rise && full && !pop) overflow <= 1'b1;
            else if (clr_ovf)             overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_system_qsys_nios2_debug_cmd_queue.sv
// Directed bench for the debug command queue: expected issues are queued by the
// stimulus and popped by a monitor whenever an action pulse appears.
module tb_system_qsys_nios2_debug_cmd_queue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] sr = '0;
    logic [1:0]  ir_in = '0;
    logic        vs_udr = 1'b0;
    logic        vs_uir = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [37:0] jdo;
    logic [3:0]  take_action, take_no_action;
    logic [2:0]  fifo_level;
    logic        overflow, ir_update;

    typedef struct packed {
        logic [3:0]  act;
        logic [3:0]  noact;
        logic [37:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    system_qsys_nios2_debug_cmd_queue dut (
        .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
        .clr_ovf(clr_ovf), .jdo(jdo), .take_action(take_action),
        .take_no_action(take_no_action), .fifo_level(fifo_level),
        .overflow(overflow), .ir_update(ir_update)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t make_exp(input logic [1:0] ir, input logic [37:0] d);
        exp_t e;
        e.data  = d;
        e.act   = d[37] ? (4'b0001 << ir) : 4'b0000;
        e.noact = d[37] ? 4'b0000 : (4'b0001 << ir);
        return e;
    endfunction

    // Monitor: every cycle carrying a pulse must match the oldest expected command.
    always @(negedge clk) begin
        if (|take_action || |take_no_action) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: act=%b noact=%b jdo=%0h, none expected",
                         take_action, take_no_action, jdo);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_action", 64'(take_action), 64'(e.act));
                check("issue_no_action", 64'(take_no_action), 64'(e.noact));
                check("issue_jdo", 64'(jdo), 64'(e.data));
            end
        end
    end

    // Hold vs_udr high three cycles; the entry is written on the third edge.
    task automatic push_cmd(input logic [1:0] ir, input logic [37:0] d, input bit issued);
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        if (issued) exp_q.push_back(make_exp(ir, d));
        repeat (3) @(negedge clk);
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #12;
        check("reset_level", 64'(fifo_level), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_jdo", 64'(jdo), 64'd0);
        check("reset_pulses", 64'({take_action, take_no_action, ir_update}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single command, minimum latency.
        cmd_ready = 1'b1;
        ir_in  = 2'd2;
        sr     = 38'h20_0000_0005;
        vs_udr = 1'b1;
        exp_q.push_back(make_exp(2'd2, 38'h20_0000_0005));
        repeat (3) @(negedge clk);
        check("single_level_after_write", 64'(fifo_level), 64'd1);
        check("single_no_early_pulse", 64'(take_action), 64'd0);
        vs_udr = 1'b0;
        @(negedge clk);
        check("single_pulse_edge4", 64'(take_action), 64'b0100);
        check("single_jdo", 64'(jdo), 64'h20_0000_0005);
        @(negedge clk);
        check("single_pulse_one_cycle", 64'(take_action), 64'd0);
        check("single_level_zero", 64'(fifo_level), 64'd0);
        check("single_jdo_hold", 64'(jdo), 64'h20_0000_0005);
        repeat (3) @(negedge clk);

        // Backpressure: three commands wait, then issue back to back.
        cmd_ready = 1'b0;
        push_cmd(2'd0, 38'h00_0000_0011, 1'b1);
        push_cmd(2'd1, 38'h00_0000_0022, 1'b1);
        push_cmd(2'd3, 38'h00_0000_0033, 1'b1);
        check("bp_level3", 64'(fifo_level), 64'd3);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("bp_first", 64'(take_no_action), 64'b0001);
        @(negedge clk);
        check("bp_second", 64'(take_no_action), 64'b0010);
        @(negedge clk);
        check("bp_third", 64'(take_no_action), 64'b1000);
        check("bp_level0", 64'(fifo_level), 64'd0);
        repeat (2) @(negedge clk);

        // Overflow: fifth push dropped, first four issue in order.
        cmd_ready = 1'b0;
        push_cmd(2'd0, 38'h20_0000_0100, 1'b1);
        push_cmd(2'd1, 38'h00_0000_0200, 1'b1);
        push_cmd(2'd2, 38'h20_0000_0300, 1'b1);
        push_cmd(2'd3, 38'h00_0000_0400, 1'b1);
        check("ovf_no_flag_at_full", 64'(overflow), 64'd0);
        push_cmd(2'd1, 38'h20_0000_0500, 1'b0);
        check("ovf_level4", 64'(fifo_level), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);
        cmd_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("ovf_drained", 64'(fifo_level), 64'd0);

        // Full queue with push and pop on the same edge.
        cmd_ready = 1'b0;
        push_cmd(2'd0, 38'h00_0000_0A01, 1'b1);
        push_cmd(2'd1, 38'h00_0000_0A02, 1'b1);
        push_cmd(2'd2, 38'h00_0000_0A03, 1'b1);
        push_cmd(2'd3, 38'h00_0000_0A04, 1'b1);
        ir_in  = 2'd2;
        sr     = 38'h20_0000_0A05;
        vs_udr = 1'b1;
        exp_q.push_back(make_exp(2'd2, 38'h20_0000_0A05));
        repeat (2) @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("full_simul_level", 64'(fifo_level), 64'd4);
        check("full_simul_overflow", 64'(overflow), 64'd0);
        vs_udr = 1'b0;
        repeat (6) @(negedge clk);
        check("full_simul_drained", 64'(fifo_level), 64'd0);
        check("full_simul_overflow_after", 64'(overflow), 64'd0);

        // Reset mid-operation discards queued commands.
        cmd_ready = 1'b0;
        push_cmd(2'd1, 38'h20_0000_0B01, 1'b0);
        push_cmd(2'd2, 38'h20_0000_0B02, 1'b0);
        check("rst_mid_level2", 64'(fifo_level), 64'd2);
        reset_n = 1'b0;
        #1;
        check("rst_mid_level", 64'(fifo_level), 64'd0);
        check("rst_mid_jdo", 64'(jdo), 64'd0);
        check("rst_mid_pulses", 64'({take_action, take_no_action, overflow, ir_update}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_level_after", 64'(fifo_level), 64'd0);

        // IR update pulse, queue untouched.
        vs_uir = 1'b1;
        repeat (2) @(negedge clk);
        check("iru_not_yet", 64'(ir_update), 64'd0);
        @(negedge clk);
        check("iru_pulse", 64'(ir_update), 64'd1);
        @(negedge clk);
        check("iru_one_cycle", 64'(ir_update), 64'd0);
        repeat (4) @(negedge clk);
        vs_uir = 1'b0;
        check("iru_level", 64'(fifo_level), 64'd0);
        repeat (3) @(negedge clk);

        // vs_udr held high across reset release: exactly one command.
        reset_n = 1'b0;
        ir_in  = 2'd1;
        sr     = 38'h3F_FFFF_FFFF;
        vs_udr = 1'b1;
        exp_q.push_back(make_exp(2'd1, 38'h3F_FFFF_FFFF));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
        check("held_level", 64'(fifo_level), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
